// File: rtl/arb_rr_4_if.sv
// Request/grant bundle between the requesting units and the 4-way round-robin arbiter.
// master = requester side, slave = arbiter side.
interface arb_rr_4_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  modport master (
    output req,
    input  gnt,
    input  gnt_id,
    input  gnt_valid,
    input  timeout
  );

  modport slave (
    input  req,
    output gnt,
    output gnt_id,
    output gnt_valid,
    output timeout
  );
endinterface

// File: rtl/arb_rr_4.sv
// Four-requester round-robin arbiter with registered one-hot grant, encoded id and hold limit.
// Define ARB_FIXED_PRIO_EN to replace round-robin with fixed priority (requester 0 highest).
module arb_rr_4 #(
  parameter int MAX_HOLD = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  arb_rr_4_if.slave   bus
);

  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HW-1:0] HOLD_LIM = HW'(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_SAT = '1;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e          state_q, state_d;
  logic [3:0]      gnt_q, gnt_d;
  logic [1:0]      gnt_id_q, gnt_id_d;
  logic            valid_q, valid_d;
  logic            timeout_q, timeout_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [HW-1:0]   hold_q, hold_d;

  logic            win_found;
  logic [1:0]      win_id;
  logic [1:0]      scan_idx;
  logic [1:0]      rel_ptr;

  // Scan from the highest offset down so the requester closest to ptr wins last.
  always_comb begin
    win_found = 1'b0;
    win_id    = ptr_q;
    scan_idx  = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      scan_idx = ptr_q + 2'(k);
      if (bus.req[scan_idx]) begin
        win_found = 1'b1;
        win_id    = scan_idx;
      end
    end
  end

`ifdef ARB_FIXED_PRIO_EN
  assign rel_ptr = 2'd0;
`else
  assign rel_ptr = gnt_id_q + 2'd1;
`endif

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    valid_d   = valid_q;
    timeout_d = 1'b0;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d  = BUSY;
          gnt_d    = 4'b0001 << win_id;
          gnt_id_d = win_id;
          valid_d  = 1'b1;
          hold_d   = HW'(1);
        end
      end
      BUSY: begin
        // A voluntary release takes precedence over the hold limit, so no timeout then.
        if (!bus.req[gnt_id_q]) begin
          state_d = IDLE;
          gnt_d   = '0;
          valid_d = 1'b0;
          ptr_d   = rel_ptr;
          hold_d  = '0;
        end else if ((MAX_HOLD > 0) && (hold_q == HOLD_LIM)) begin
          state_d   = IDLE;
          gnt_d     = '0;
          valid_d   = 1'b0;
          ptr_d     = rel_ptr;
          hold_d    = '0;
          timeout_d = 1'b1;
        end else if (hold_q != HOLD_SAT) begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      ptr_q     <= '0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_id    = gnt_id_q;
  assign bus.gnt_valid = valid_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_arb_rr_4.sv
// Directed self-checking bench for arb_rr_4 (MAX_HOLD=8), round-robin or fixed priority
// depending on ARB_FIXED_PRIO_EN.
module tb_arb_rr_4;

  logic clk;
  logic rst_n;
  int   numChecks;
  int   numFailures;
  logic [1:0] own;
  logic [3:0] ownMask;
  logic [1:0] toWinner;

  arb_rr_4_if bus ();

  arb_rr_4 #(.MAX_HOLD(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
    numChecks++;
    if (actual !== expected) begin
      numFailures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic expectOut(input string tag, input logic [3:0] g, input logic [1:0] id,
                           input logic v, input logic to);
    checkOutput({tag, ".gnt"},       8'(bus.gnt),       8'(g));
    checkOutput({tag, ".gnt_id"},    8'(bus.gnt_id),    8'(id));
    checkOutput({tag, ".gnt_valid"}, 8'(bus.gnt_valid), 8'(v));
    checkOutput({tag, ".timeout"},   8'(bus.timeout),   8'(to));
  endtask

  // Drive req, let one rising edge sample it, then settle before checking.
  task automatic applyStimulus(input logic [3:0] r);
    bus.req = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    numChecks   = 0;
    numFailures = 0;
    rst_n   = 1'b0;
    bus.req = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    expectOut("reset", 4'b0000, 2'd0, 1'b0, 1'b0);

    rst_n = 1'b1;
    applyStimulus(4'b1111);
    expectOut("first_grant", 4'b0001, 2'd0, 1'b1, 1'b0);
    applyStimulus(4'b1110);
    expectOut("first_release", 4'b0000, 2'd0, 1'b0, 1'b0);
    applyStimulus(4'b0000);
    expectOut("idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b0100);
      expectOut("single", 4'b0100, 2'd2, 1'b1, 1'b0);
    end
    applyStimulus(4'b0000);
    expectOut("single_rel", 4'b0000, 2'd2, 1'b0, 1'b0);

    applyStimulus(4'b1000);
    expectOut("wrap_own3", 4'b1000, 2'd3, 1'b1, 1'b0);
    applyStimulus(4'b0001);
    expectOut("wrap_rel3", 4'b0000, 2'd3, 1'b0, 1'b0);
    applyStimulus(4'b1001);
    expectOut("wrap_own0", 4'b0001, 2'd0, 1'b1, 1'b0);

    #2;
    rst_n = 1'b0;
    #1;
    expectOut("async_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(4'b0000);
    expectOut("post_reset_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    for (int i = 0; i < 5; i++) begin
`ifdef ARB_FIXED_PRIO_EN
      own = 2'd0;
`else
      own = 2'(i % 4);
`endif
      ownMask = 4'b0001 << own;
      applyStimulus(4'b1111);
      expectOut("rr_grant", ownMask, own, 1'b1, 1'b0);
      applyStimulus(4'b1111);
      expectOut("rr_hold", ownMask, own, 1'b1, 1'b0);
      applyStimulus(4'b1111 & ~ownMask);
      expectOut("rr_release", 4'b0000, own, 1'b0, 1'b0);
    end
    applyStimulus(4'b0000);
    expectOut("rr_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(4'b0010);
      expectOut("hold", 4'b0010, 2'd1, 1'b1, 1'b0);
    end
    applyStimulus(4'b0010);
    expectOut("hold_timeout", 4'b0000, 2'd1, 1'b0, 1'b1);
    applyStimulus(4'b0010);
    expectOut("hold_regrant", 4'b0010, 2'd1, 1'b1, 1'b0);
    applyStimulus(4'b0000);
    expectOut("hold_rel", 4'b0000, 2'd1, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(4'b0011);
      expectOut("tofair_hold", 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    applyStimulus(4'b0011);
    expectOut("tofair_timeout", 4'b0000, 2'd0, 1'b0, 1'b1);
`ifdef ARB_FIXED_PRIO_EN
    toWinner = 2'd0;
`else
    toWinner = 2'd1;
`endif
    applyStimulus(4'b0011);
    expectOut("tofair_next", 4'b0001 << toWinner, toWinner, 1'b1, 1'b0);
    applyStimulus(4'b0000);
    expectOut("tofair_rel", 4'b0000, toWinner, 1'b0, 1'b0);

    applyStimulus(4'b0100);
    expectOut("simul_grant", 4'b0100, 2'd2, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(4'b0101);
      expectOut("simul_ignore", 4'b0100, 2'd2, 1'b1, 1'b0);
    end
    applyStimulus(4'b0000);
    expectOut("simul_release", 4'b0000, 2'd2, 1'b0, 1'b0);
    applyStimulus(4'b0000);
    expectOut("simul_idle", 4'b0000, 2'd2, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", numChecks, numFailures);
    $finish;
  end

endmodule
